// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Word-addressed data memory with fixed access latency and
//            request/response handshakes; one request in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int N       = 32,
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         busy
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [AW+1:0] r_addr;
    logic [N-1:0]  r_wdata;
    logic [N-1:0]  r_rdata;
    logic          r_err;
    logic [N-1:0]  r_mem [0:(2**AW)-1];

    logic          w_commit;
    logic          w_aligned;
    logic          w_wr_en;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    // Address bits above the word index only alias, so they are dropped.
    assign w_unused_addr = ^req_addr[N-1:AW+2];

    assign w_idx     = r_addr[AW+1:2];
    assign w_aligned = (r_addr[1:0] == 2'b00);
    assign w_commit  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_wr_en   = !reset && w_commit && r_we && w_aligned;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr[AW+1:0];
                        r_wdata <= req_wdata;
                        r_cnt   <= c_cnt_init;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Misaligned accesses touch nothing and report an error.
                        if (!w_aligned) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else if (r_we) begin
                            r_rdata <= r_wdata;
                        end else begin
                            r_rdata <= r_mem[w_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder at LATENCY 2, 1 and 15.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .N       (32),
            .AW      (8),
            .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          hold;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mm [3][256];
    vec_t        tbl [12];

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference memory: byte address -> word, aliasing modulo 1 KiB.
    task automatic model(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] er, output logic ee);
        int idx;
        idx = int'((addr / 4) % 256);
        if (addr % 4 != 0) begin
            er = 0; ee = 1;
        end else if (we) begin
            mm[d][idx] = wdata; er = wdata; ee = 0;
        end else begin
            er = mm[d][idx]; ee = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] idle_pat(input int d);
        return {27'd0, req_ready[d], rsp_valid[d], busy[d], rsp_err[d], rsp_rdata[d] == 32'd0};
    endfunction

    task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold, input string tag);
        int          t;
        logic        ok;
        logic [31:0] rd;
        t = 0;
        while (!req_ready[d] && t < 50) begin tick(); t++; end
        req_valid[d] = 1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        rsp_ready[d] = (hold == 0);
        tick();
        req_valid[d] = 0; req_we[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
        ok = 1; t = 0;
        while (!rsp_valid[d] && t < 40) begin
            if (!busy[d] || req_ready[d]) ok = 0;
            tick(); t++;
        end
        if (!busy[d]) ok = 0;
        check({tag, " latency"}, 32'(t), 32'(lat_of(d)));
        check({tag, " busy"}, {31'd0, ok}, 32'd1);
        rd = rsp_rdata[d];
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " err"}, {31'd0, rsp_err[d]}, {31'd0, exp_err});
        if (hold > 0) begin
            ok = 1;
            for (int i = 0; i < hold; i++) begin
                req_valid[d] = (i == 0); req_we[d] = 1; req_addr[d] = addr; req_wdata[d] = ~wdata;
                tick();
                if (!rsp_valid[d] || rsp_rdata[d] !== rd || req_ready[d] || !busy[d]) ok = 0;
            end
            req_valid[d] = 0;
            check({tag, " stall"}, {31'd0, ok}, 32'd1);
            rsp_ready[d] = 1;
        end
        tick();
        check({tag, " idle"}, idle_pat(d), 32'b10001);
        rsp_ready[d] = 0;
    endtask

    initial begin
        logic [31:0] er;
        logic        ee;
        int          t;

        tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0};
        tbl[1]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0};
        tbl[2]  = '{1'b1, 32'h13,  32'h1234,     32'h0,        1'b1, 0};
        tbl[3]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0};
        tbl[4]  = '{1'b0, 32'h410, 32'h0,        32'hDEADBEEF, 1'b0, 0};
        tbl[5]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 5};
        tbl[6]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0};
        tbl[7]  = '{1'b1, 32'h404, 32'h55,       32'h55,       1'b0, 0};
        tbl[8]  = '{1'b0, 32'h4,   32'h0,        32'h55,       1'b0, 0};
        tbl[9]  = '{1'b0, 32'h2,   32'h0,        32'h0,        1'b1, 0};
        tbl[10] = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 2};
        tbl[11] = '{1'b0, 32'h7FC, 32'h0,        32'hA5A5A5A5, 1'b0, 1};

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 256; i++) mm[d][i] = 32'd0;
            req_valid[d] = 0; req_we[d] = 0; req_addr[d] = 0; req_wdata[d] = 0; rsp_ready[d] = 0;
        end

        reset = 1;
        tick(); tick();
        reset = 0;
        for (int d = 0; d < 3; d++) check($sformatf("reset%0d", d), idle_pat(d), 32'b10001);

        for (int i = 0; i < 12; i++) begin
            model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, er, ee);
            txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err, tbl[i].hold,
                $sformatf("vec%0d", i));
        end

        // Reset while the store is still waiting: nothing may be written.
        req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFEF00D;
        rsp_ready[0] = 1;
        tick();
        req_valid[0] = 0; reset = 1;
        tick();
        reset = 0;
        check("rst_wait", idle_pat(0), 32'b10001);
        txn(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0, "rst_wait_load");

        // Reset while a response is pending: the response is dropped.
        req_valid[0] = 1; req_we[0] = 0; req_addr[0] = 32'h10; rsp_ready[0] = 0;
        tick();
        req_valid[0] = 0; t = 0;
        while (!rsp_valid[0] && t < 40) begin tick(); t++; end
        reset = 1;
        tick();
        reset = 0;
        check("rst_resp", idle_pat(0), 32'b10001);

        for (int d = 1; d < 3; d++) begin
            model(d, 1'b1, 32'h44, 32'h600D0000 + d, er, ee);
            txn(d, 1'b1, 32'h44, 32'h600D0000 + d, er, ee, 0, $sformatf("sweep%0d_st", d));
            model(d, 1'b0, 32'h44, 32'h0, er, ee);
            txn(d, 1'b0, 32'h44, 32'h0, er, ee, 1, $sformatf("sweep%0d_ld", d));
        end

        for (int i = 0; i < 60; i++) begin
            int          d;
            logic        we;
            logic [31:0] addr;
            logic [31:0] wd;
            d    = int'($urandom_range(0, 2));
            we   = 1'($urandom);
            addr = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            wd   = $urandom;
            model(d, we, addr, wd, er, ee);
            txn(d, we, addr, wd, er, ee, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
